// File: rtl/qif_spike_monitor.sv
// rtl/qif_spike_monitor.sv - spike counter and inter-spike-interval monitor with show-ahead ISI FIFO
// Optional refractory filter: define QIF_MON_REFRACT_EN to discard events closer than REFRACT cycles.
module qif_spike_monitor #(
  parameter int FIFO_DEPTH = 4,
  parameter int REFRACT    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       spike_in,
  input  logic       start,
  input  logic       stop,
  output logic [7:0] isi_data,
  output logic       isi_valid,
  input  logic       isi_rd,
  output logic [7:0] spike_count,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

`ifdef QIF_MON_REFRACT_EN
  localparam bit REFRACT_ON = 1'b1;
`else
  localparam bit REFRACT_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_MEAS  = 2'd2
  } state_e;

  state_e      state_q;
  logic        busy_q;
  logic        spike_d_q;
  logic [7:0]  spike_count_q;
  logic [7:0]  isi_cnt_q;
  logic        overflow_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  logic        event_w;
  logic        too_soon;
  logic        accept_w;
  logic        fifo_empty;
  logic        fifo_full;
  logic        do_pop;
  logic        do_push;
  logic        drop_w;
  logic [7:0]  isi_inc;
  logic [7:0]  cnt_inc;

  // Event detection, FIFO status and push/pop decisions for this cycle
  always_comb begin
    event_w    = spike_in & ~spike_d_q & ena;
    isi_inc    = (isi_cnt_q == 8'hFF) ? 8'hFF : isi_cnt_q + 8'd1;
    cnt_inc    = (spike_count_q == 8'hFF) ? 8'hFF : spike_count_q + 8'd1;
    // isi_cnt+1 is the interval this event would report; too short means a bounce
    too_soon   = REFRACT_ON && (({1'b0, isi_cnt_q} + 9'd1) < 9'(REFRACT));
    accept_w   = (state_q == S_MEAS) && event_w && !too_soon && !start && !stop;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop     = ena && isi_rd && !fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    do_push    = accept_w && (!fifo_full || do_pop);
    drop_w     = accept_w && fifo_full && !do_pop;
  end

  // Previous spike level, tracked every cycle so a spike rising under ena=0 is not seen later
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spike_d_q <= 1'b0;
    end else begin
      spike_d_q <= spike_in;
    end
  end

  // Measurement FSM with spike counter, interval counter and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      spike_count_q <= 8'd0;
      isi_cnt_q     <= 8'd0;
      overflow_q    <= 1'b0;
    end else if (ena) begin
      if (stop) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else if (start) begin
        state_q       <= S_ARMED;
        busy_q        <= 1'b1;
        spike_count_q <= 8'd0;
        isi_cnt_q     <= 8'd0;
        overflow_q    <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            busy_q <= 1'b0;
          end
          S_ARMED: begin
            busy_q <= 1'b1;
            if (event_w) begin
              state_q       <= S_MEAS;
              spike_count_q <= 8'd1;
              isi_cnt_q     <= 8'd0;
            end
          end
          S_MEAS: begin
            busy_q <= 1'b1;
            if (accept_w) begin
              isi_cnt_q     <= 8'd0;
              spike_count_q <= cnt_inc;
              if (drop_w) begin
                overflow_q <= 1'b1;
              end
            end else begin
              isi_cnt_q <= isi_inc;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= isi_inc;
    end
  end

  assign isi_valid   = !fifo_empty;
  assign isi_data    = fifo_empty ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign spike_count = spike_count_q;
  assign overflow    = overflow_q;
  assign busy        = busy_q;

endmodule

// File: doc/qif_spike_monitor.md
# qif_spike_monitor

Downstream analysis stage for the 8-bit QIF neuron. Consumes the neuron's spike output, counts spikes and measures inter-spike intervals (ISI) in clock cycles. Buffers ISI results in a small show-ahead FIFO for a readout host under a valid/read handshake. Lets a bench or on-chip logic characterise firing rate without capturing the raw spike train.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: ISI FIFO entries (power of two, ≥2).
- `REFRACT`, 2: minimum accepted ISI in cycles; used only with `QIF_MON_REFRACT_EN`.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `ena`  in  1  block enable; low freezes all state except reset.
- `spike_in`  in  1  neuron spike level; each rising edge is one spike event.
- `start`  in  1  one-cycle pulse; arms measurement.
- `stop`  in  1  one-cycle pulse; returns to IDLE.
- `isi_data`  out  8  ISI at FIFO head; 0 when empty.
- `isi_valid`  out  1  FIFO not empty.
- `isi_rd`  in  1  pop head when `isi_valid`.
- `spike_count`  out  8  spikes accepted since last `start`, saturating.
- `overflow`  out  1  sticky: an ISI was dropped because the FIFO was full.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Edge detect: `spike_d` register, reset 0, updated every cycle regardless of `ena`. Event = `spike_in & ~spike_d & ena`.
- FSM states: IDLE, ARMED, MEASURING.
  - IDLE: `start` → ARMED. Events ignored.
  - ARMED: first event → MEASURING. `spike_count` becomes 1, `isi_cnt` becomes 0. No FIFO push.
  - MEASURING: each cycle with `ena` high and no event, `isi_cnt` increments, saturating at 255.
    - On event: push `min(isi_cnt+1, 255)`. Clear `isi_cnt` to 0. Increment `spike_count`, saturating at 255.
  - Any state: `stop` → IDLE. `start` in ARMED or MEASURING → ARMED, re-armed.
  - Simultaneous `start` and `stop`: `stop` wins.
  - `start` clears `spike_count`, `isi_cnt` and `overflow`. It does not flush the FIFO.
- ISI semantics: events at cycles t and t+5 push 5.
- FIFO:
  - Show-ahead. `isi_data` is the head entry.
  - Push when full: entry dropped, `overflow` set.
  - Push and pop in the same cycle when full: both occur, no overflow.
  - Pop when empty: ignored.
  - `stop` leaves FIFO contents intact.
- Reset values:
  - Outputs: `isi_data`=0, `isi_valid`=0, `spike_count`=0, `overflow`=0, `busy`=0.
  - Internal: state IDLE, FIFO empty, `isi_cnt`=0.
- Reset mid-operation discards everything, including FIFO contents, on the next clock edge.

## Timing
- `spike_in` rises, sampled at edge k → FIFO write and `spike_count` update at edge k.
- `isi_valid`, `isi_data` and `spike_count` are visible in the cycle after edge k. Latency is one cycle.
- `isi_rd` sampled at edge j with `isi_valid`=1 → the next entry, or `isi_valid`=0, is visible after edge j.
- `start`/`stop` take effect at the edge where sampled. `busy` updates in the following cycle.
- A spike held high for several cycles is one event. Back-to-back events need `spike_in` low for ≥1 sampled cycle. Minimum ISI is 2.

## Configuration
- `QIF_MON_REFRACT_EN` defined:
  - In MEASURING, an event is discarded when `isi_cnt+1 < REFRACT`.
  - A discarded event causes no push, no count and no counter clear. `isi_cnt` keeps incrementing.
- Undefined: every event is accepted and `REFRACT` is unused.

## Test plan
- Reset then idle: spikes on `spike_in` with no `start` → `spike_count`=0, `isi_valid`=0, `busy`=0.
- `start`, then spikes at cycles 10, 15, 25 → FIFO holds 5, 10. `spike_count`=3. Reading twice returns 5 then 10, then `isi_valid`=0.
- `start`, spike, then no spike for 300 cycles, then spike → pushed ISI=255.
- `start`, then 6 spikes 3 cycles apart with no reads → 4 entries of 3 retained, `overflow`=1. Next `start` clears `overflow` and leaves FIFO contents.
- FIFO full with `isi_rd`=1 in the same cycle as a spike event → count stays 4, no overflow, head advances.
- With `QIF_MON_REFRACT_EN` and `REFRACT`=4: spikes at 0, 2, 6 → one push of 6, `spike_count`=2.
